// File: rtl/mem_pkg.sv
// Shared constants for the SRAM memory bridge: FSM encoding,
// core wr encoding and the wait-state limit.
package mem_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;

  localparam logic MEM_WRITE = 1'b0;
  localparam logic MEM_READ  = 1'b1;

  localparam int WAIT_MAX = 15;

  // Out-of-range wait settings saturate at the legal maximum.
  function automatic logic [3:0] wait_load(input int w);
    if (w > WAIT_MAX) return 4'(WAIT_MAX);
    if (w < 0) return 4'd0;
    return 4'(w);
  endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// 4-bit wait-state down-counter: load, enable, zero flag.
// Ports: clk, reset, load, en, load_val[3:0] in; zero out.
module mem_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_bridge.sv
// Core-to-async-SRAM bridge with programmable wait states.
// Ports: cpu_* request/response, sram_* pins, busy, rd/wr counters.
module mem_bridge
  import mem_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          busy,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  output logic          sram_dout_en,
  input  logic [DW-1:0] sram_din,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam logic [3:0] WAIT_LD = wait_load(WAIT_CYCLES);

  logic [1:0] state;
  logic       wr_q;
  logic       cnt_zero;

  mem_wait_cnt u_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (state == SETUP),
    .en       (state == ACCESS),
    .load_val (WAIT_LD),
    .zero     (cnt_zero)
  );

  // Every output is set for the state being entered, so all
  // pins are plain flops with no input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wr_q         <= MEM_READ;
      cpu_rdata    <= '0;
      cpu_ready    <= 1'b0;
      busy         <= 1'b0;
      sram_addr    <= '0;
      sram_dout    <= '0;
      sram_dout_en <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      rd_count     <= 16'd0;
      wr_count     <= 16'd0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            state     <= SETUP;
            busy      <= 1'b1;
            sram_ce_n <= 1'b0;
            sram_addr <= cpu_addr;
            wr_q      <= cpu_wr;
            if (cpu_wr == MEM_WRITE) begin
              sram_dout    <= cpu_wdata;
              sram_dout_en <= 1'b1;
            end
          end
        end
        SETUP: begin
          state     <= ACCESS;
          sram_oe_n <= (wr_q != MEM_READ);
          sram_we_n <= (wr_q != MEM_WRITE);
        end
        ACCESS: begin
          if (cnt_zero) begin
            state     <= HOLD;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            cpu_ready <= 1'b1;
            if (wr_q == MEM_READ) begin
              cpu_rdata <= sram_din;
              rd_count  <= rd_count + 16'd1;
            end else begin
              wr_count  <= wr_count + 16'd1;
            end
          end
        end
        HOLD: begin
          state        <= IDLE;
          busy         <= 1'b0;
          sram_ce_n    <= 1'b1;
          sram_dout_en <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Downstream memory stage of the CPU core. Consumes the core's address bus, write-enable (wr) and write data, and runs timed cycles on an external asynchronous SRAM with programmable wait states.
- Returns read data and a one-cycle ready pulse to the core side.
- Carries read and write access counters that the debug/reg_data path can display.

Parameters:
- AW, 16, address width
- DW, 16, data width
- WAIT_CYCLES, 1, extra cycles the SRAM strobe stays low beyond one; legal range 0..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  access request; held high by requester until cpu_ready seen
- cpu_wr  in  1  core wr encoding: 0 = write, 1 = read
- cpu_addr  in  AW  access address
- cpu_wdata  in  DW  write data
- cpu_rdata  out  DW  read data, valid while cpu_ready=1 and held until next read completes
- cpu_ready  out  1  one-cycle completion pulse
- busy  out  1  high in any state other than IDLE
- sram_addr  out  AW  SRAM address
- sram_dout  out  DW  SRAM write data
- sram_dout_en  out  1  drive enable for SRAM data pins
- sram_din  in  DW  SRAM read data
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- rd_count  out  16  completed reads, wraps 0xFFFF->0
- wr_count  out  16  completed writes, wraps 0xFFFF->0

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state IDLE; cpu_ready=0; busy=0; sram_ce_n=sram_oe_n=sram_we_n=1; sram_dout_en=0; sram_addr=0; sram_dout=0; cpu_rdata=0; rd_count=0; wr_count=0.
- Registered outputs: all outputs are registered (Moore). There is no combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - On cpu_req=1, latch cpu_addr, cpu_wdata and cpu_wr, then go to SETUP.
  - On cpu_req=0, remain in IDLE.
- SETUP (1 cycle): ce_n=0, address valid, oe_n=we_n=1. On a write, sram_dout_en=1 and sram_dout=latched data. Next state is ACCESS, with the wait counter loaded to WAIT_CYCLES.
- ACCESS (WAIT_CYCLES+1 cycles):
  - Read: oe_n=0. Write: we_n=0.
  - The counter decrements each cycle. When it is 0, go to HOLD.
  - Read: on the cycle the counter is 0, capture sram_din into cpu_rdata.
- HOLD (1 cycle):
  - Strobes return high. ce_n stays 0; address and data stay stable (write hold time).
  - cpu_ready=1 for this cycle only.
  - Increment rd_count or wr_count.
  - Next state is always IDLE; cpu_req is ignored in HOLD.
- Leaving HOLD: ce_n=1 and sram_dout_en=0.
- Latency: the request is accepted at edge k. cpu_ready is high in the cycle following edge k+2+WAIT_CYCLES. Total occupancy is WAIT_CYCLES+3 cycles (4 for the default).
- Back-to-back: minimum spacing between accepted requests is WAIT_CYCLES+4 cycles (one IDLE cycle between accesses).
- cpu_req changes while busy are ignored; the latched address, data and direction are used throughout.
- Reset mid-access: at the reset edge the FSM returns to IDLE and all strobes deassert. cpu_ready is not pulsed and the counters clear.
- sram_oe_n and sram_we_n are never low in the same cycle. sram_dout_en=1 only during a write SETUP/ACCESS/HOLD.
- WAIT_CYCLES=0: ACCESS lasts exactly 1 cycle.

Decomposition:
- Shared package (mem_pkg):
  - state encoding: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, HOLD=2'd3
  - constants MEM_WRITE=1'b0 and MEM_READ=1'b1, matching the core's wr encoding
  - WAIT_CYCLES legal maximum 15
- One sub-module, mem_wait_cnt: 4-bit down-counter with load, enable and a zero flag. Used by ACCESS and reusable by future peripheral bridges.

Test Plan:
- Reset then idle: hold reset for 2 cycles -> all SRAM strobes =1, busy=0, counters=0, cpu_rdata=0.
- Write, WAIT_CYCLES=1: req with wr=0, addr=0x0010, wdata=0xBEEF -> we_n low exactly 2 cycles; address and data stable from SETUP through HOLD; ready pulses once 4 cycles after acceptance; wr_count=1.
- Read back: req with wr=1, addr=0x0010 against SRAM model -> oe_n low 2 cycles, we_n stays 1, cpu_rdata=0xBEEF with ready, rd_count=1.
- WAIT_CYCLES=0 and 15 (two builds): back-to-back reads of 0x0000 and 0xFFFF -> ACCESS length 1 and 16 cycles; acceptance spacing 4 and 19 cycles.
- Mid-access changes: cpu_addr changes to 0x1234 during ACCESS of a read at 0x0020 -> sram_addr stays 0x0020; result is from 0x0020.
- Reset mid-write: assert reset during ACCESS -> next edge we_n=1, ce_n=1, dout_en=0, no ready pulse, wr_count=0; a wr_count preloaded by 0x10000 writes (wrap check in a separate run) reads 0.
